ysyx_24120006_ifu: RTL and testbench

Instruction fetch unit for the single-issue multi-cycle NPC core. It owns the architectural PC, issues one fetch per instruction to instruction memory, hands the fetched word and its PC to decode/execute, then waits for the next-PC value produced downstream before fetching again. It is the consumer of the next-PC path and the producer of the `instr`/`pc` pair that the next-PC logic reads.

---
 rtl/ysyx_24120006_ifu_if.sv | 57 +++++
 rtl/ysyx_24120006_ifu.sv | 126 ++++++++++++
 tb/tb_ysyx_24120006_ifu.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24120006_ifu_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, the
// instruction hand-off to decode/execute, and the returning next-PC.
interface ysyx_24120006_ifu_if;
    localparam int unsigned XLEN = 32;

    // instruction memory request
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;

    // instruction memory response (no ready: must be taken)
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            imem_resp_err;

    // instruction hand-off to downstream
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;

    // next PC returned by downstream
    logic            npc_valid;
    logic [XLEN-1:0] npc;

    // fetch unit side
    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  imem_resp_err,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc,
        input  npc_valid,
        input  npc
    );

    // memory / downstream side
    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_resp_valid,
        output imem_resp_data,
        output imem_resp_err,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc,
        output npc_valid,
        output npc
    );
endinterface

// File: rtl/ysyx_24120006_ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time, hands the
// word downstream and waits for the next PC before fetching again.
module ysyx_24120006_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_24120006_ifu_if.master        bus,
    output logic                       fetch_fault,
    output logic [31:0]                fetch_count
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        ISSUE = 3'd3,
        EXEC  = 3'd4,
        HALT  = 3'd5
    } state_e;

    state_e          state_q;
    state_e          state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inst_q;
    logic [XLEN-1:0] inst_pc_q;
    logic [XLEN-1:0] count_q;

    logic            npc_aligned;
    logic            resp_take;
    logic            issue_fire;
    logic            npc_take;

    // Qualified events; each is only meaningful in its own state
    assign npc_aligned = (bus.npc[1:0] == 2'b00);
    assign resp_take   = (state_q == WAIT)  && bus.imem_resp_valid && !bus.imem_resp_err;
    assign issue_fire  = (state_q == ISSUE) && bus.inst_ready;
    assign npc_take    = (state_q == EXEC)  && bus.npc_valid && npc_aligned;

    // State register; reset wins over every transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (bus.imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_resp_valid) begin
                    state_d = bus.imem_resp_err ? HALT : ISSUE;
                end
            end
            ISSUE: begin
                if (bus.inst_ready) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (bus.npc_valid) begin
                    state_d = npc_aligned ? FETCH : HALT;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from registered state only
    always_comb begin
        bus.imem_req_valid = 1'b0;
        bus.inst_valid     = 1'b0;
        fetch_fault        = 1'b0;
        case (state_q)
            FETCH:   bus.imem_req_valid = 1'b1;
            ISSUE:   bus.inst_valid     = 1'b1;
            HALT:    fetch_fault        = 1'b1;
            default: ;
        endcase
    end

    // PC, captured instruction and issue counter
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
            count_q   <= '0;
        end else begin
            if (npc_take) begin
                pc_q <= bus.npc;
            end
            if (resp_take) begin
                inst_q    <= bus.imem_resp_data;
                inst_pc_q <= pc_q;
            end
            if (issue_fire) begin
                count_q <= count_q + XLEN'(1);
            end
        end
    end

    assign bus.imem_req_addr = pc_q;
    assign bus.inst          = inst_q;
    assign bus.inst_pc       = inst_pc_q;
    assign fetch_count       = count_q;

endmodule

// File: tb/tb_ysyx_24120006_ifu.sv
// Self-checking bench for the instruction fetch unit.
module tb_ysyx_24120006_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef struct {
        int          req_stall;
        int          resp_dly;
        int          rdy_dly;
        int          npc_dly;
        logic [31:0] data;
        logic        err;
        logic [31:0] npc;
        logic [31:0] exp_addr;
        logic        exp_fault;
        logic [31:0] exp_count;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int    total    = 0;
    int    bad      = 0;
    int    cyc      = 0;
    int    last_acc = 0;
    string cur_tag  = "init";

    ysyx_24120006_ifu_if bus();

    ysyx_24120006_ifu #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .fetch_fault (fetch_fault),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog expired in %s", cur_tag);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s actual=%0h required=%0h", cur_tag, name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.imem_resp_err   = 1'b0;
        bus.inst_ready      = 1'b0;
        bus.npc_valid       = 1'b0;
        bus.npc             = 32'h0;
    endtask

    // Reset for two edges, release at a falling edge and check the IDLE cycle
    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_req_valid",  bus.imem_req_valid, 32'd0);
        chk("rst_inst_valid", bus.inst_valid,     32'd0);
        chk("rst_fault",      fetch_fault,        32'd0);
        chk("rst_count",      fetch_count,        32'd0);
        chk("rst_inst",       bus.inst,           32'd0);
        chk("rst_inst_pc",    bus.inst_pc,        32'd0);
    endtask

    // Hold every input active while halted; nothing may leave the unit
    task automatic check_halted(input int n);
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b1;
        bus.inst_ready      = 1'b1;
        bus.npc_valid       = 1'b1;
        bus.npc             = 32'h8000_0040;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("halt_req_valid",  bus.imem_req_valid, 32'd0);
            chk("halt_inst_valid", bus.inst_valid,     32'd0);
            chk("halt_fault",      fetch_fault,        32'd1);
        end
        clear_inputs();
    endtask

    // Drive one full instruction transaction and check it against v
    task automatic do_instr(input vec_t v);
        int n;
        n = 0;
        while (!bus.imem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_valid", bus.imem_req_valid, 32'd1);
        chk("req_addr",  bus.imem_req_addr,  v.exp_addr);
        for (int i = 0; i < v.req_stall; i++) begin
            @(negedge clk);
            chk("req_hold",      bus.imem_req_valid, 32'd1);
            chk("req_addr_hold", bus.imem_req_addr,  v.exp_addr);
        end
        bus.imem_req_ready = 1'b1;
        last_acc = cyc;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        chk("single_req", bus.imem_req_valid, 32'd0);
        // stray next-PC while the fetch is outstanding must be ignored
        for (int i = 0; i < v.resp_dly; i++) begin
            bus.npc_valid      = 1'b1;
            bus.npc            = 32'h0000_0100;
            bus.imem_req_ready = 1'b1;
            @(negedge clk);
            chk("wait_no_req",  bus.imem_req_valid, 32'd0);
            chk("wait_no_inst", bus.inst_valid,     32'd0);
        end
        bus.npc_valid       = 1'b0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = v.data;
        bus.imem_resp_err   = v.err;
        @(negedge clk);
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_err   = 1'b0;
        bus.imem_resp_data  = $urandom;
        if (v.err) begin
            chk("err_fault",    fetch_fault,        32'(v.exp_fault));
            chk("err_no_issue", bus.inst_valid,     32'd0);
            chk("err_no_req",   bus.imem_req_valid, 32'd0);
            return;
        end
        chk("inst_valid", bus.inst_valid, 32'd1);
        chk("inst",       bus.inst,       v.data);
        chk("inst_pc",    bus.inst_pc,    v.exp_addr);
        for (int i = 0; i < v.rdy_dly; i++) begin
            bus.npc_valid = 1'b1;
            bus.npc       = 32'h0000_0200;
            @(negedge clk);
            chk("issue_hold",    bus.inst_valid, 32'd1);
            chk("inst_hold",     bus.inst,       v.data);
            chk("inst_pc_hold",  bus.inst_pc,    v.exp_addr);
        end
        bus.npc_valid  = 1'b0;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        chk("count",         fetch_count,    v.exp_count);
        chk("issue_dropped", bus.inst_valid, 32'd0);
        for (int i = 0; i < v.npc_dly; i++) begin
            @(negedge clk);
            chk("exec_no_req", bus.imem_req_valid, 32'd0);
        end
        bus.npc_valid = 1'b1;
        bus.npc       = v.npc;
        @(negedge clk);
        bus.npc_valid = 1'b0;
        chk("npc_fault", fetch_fault, 32'(v.exp_fault));
        if (v.exp_fault) begin
            chk("fault_no_req", bus.imem_req_valid, 32'd0);
        end else begin
            chk("next_req",  bus.imem_req_valid, 32'd1);
            chk("next_addr", bus.imem_req_addr,  v.npc);
        end
    endtask

    vec_t        tbl [4];
    vec_t        v;
    logic [31:0] exp_pc;
    logic [31:0] exp_count;
    logic        halted;
    logic [31:0] r32;
    int          prev_acc;
    int          r;

    initial begin
        clear_inputs();

        // first fetch timing after reset
        cur_tag = "first";
        do_reset();
        @(negedge clk);
        chk("c1_req_valid", bus.imem_req_valid, 32'd1);
        chk("c1_req_addr",  bus.imem_req_addr,  RESET_PC);
        chk("c1_inst_valid", bus.inst_valid,    32'd0);
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h0000_0013;
        @(negedge clk);
        bus.imem_resp_valid = 1'b0;
        chk("c3_inst_valid", bus.inst_valid, 32'd1);
        chk("c3_inst_pc",    bus.inst_pc,    RESET_PC);
        chk("c3_inst",       bus.inst,       32'h0000_0013);
        chk("c3_count",      fetch_count,    32'd0);
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        chk("c4_count", fetch_count, 32'd1);

        // ten sequential instructions at full rate
        cur_tag = "seq";
        do_reset();
        prev_acc = 0;
        for (int i = 0; i < 10; i++) begin
            v = '{0, 0, 0, 0, $urandom, 1'b0, RESET_PC + 32'(4 * (i + 1)),
                  RESET_PC + 32'(4 * i), 1'b0, 32'(i + 1)};
            do_instr(v);
            if (i > 0) chk("cycles_per_inst", 32'(last_acc - prev_acc), 32'd4);
            prev_acc = last_acc;
        end
        chk("seq_total", fetch_count, 32'd10);

        // table: backpressure, jump, delays, misaligned next PC
        cur_tag = "table";
        tbl[0] = '{0, 0, 0, 0, 32'h0000_0013, 1'b0, 32'h8000_0004, 32'h8000_0000, 1'b0, 32'd1};
        tbl[1] = '{3, 0, 5, 0, 32'h0010_0093, 1'b0, 32'h8000_1000, 32'h8000_0004, 1'b0, 32'd2};
        tbl[2] = '{0, 2, 0, 3, 32'h0020_0113, 1'b0, 32'h8000_1004, 32'h8000_1000, 1'b0, 32'd3};
        tbl[3] = '{1, 1, 1, 1, 32'h0030_0193, 1'b0, 32'h8000_1002, 32'h8000_1004, 1'b1, 32'd4};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_instr(tbl[i]);
        end
        check_halted(8);
        chk("table_count_frozen", fetch_count, 32'd4);

        // access fault, then recovery through reset
        cur_tag = "resp_err";
        do_reset();
        v = '{0, 1, 0, 0, 32'hDEAD_BEEF, 1'b1, 32'h0, RESET_PC, 1'b1, 32'd0};
        do_instr(v);
        chk("err_inst_unchanged", bus.inst, 32'd0);
        check_halted(5);
        chk("err_count", fetch_count, 32'd0);
        do_reset();
        v = '{0, 0, 0, 0, 32'h0000_0513, 1'b0, 32'h8000_0008, RESET_PC, 1'b0, 32'd1};
        do_instr(v);

        // reset while a fetch is outstanding; late response ignored
        cur_tag = "rst_wait";
        do_reset();
        @(negedge clk);
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("rw_req_valid",  bus.imem_req_valid, 32'd1);
        chk("rw_req_addr",   bus.imem_req_addr,  RESET_PC);
        chk("rw_inst_valid", bus.inst_valid,     32'd0);
        chk("rw_inst",       bus.inst,           32'd0);
        chk("rw_count",      fetch_count,        32'd0);
        @(negedge clk);
        chk("rw_still_fetch", bus.imem_req_valid, 32'd1);
        chk("rw_no_issue",    bus.inst_valid,     32'd0);
        bus.imem_resp_valid = 1'b0;

        // randomized traffic against a transaction-level model
        cur_tag = "random";
        do_reset();
        exp_pc    = RESET_PC;
        exp_count = 32'd0;
        halted    = 1'b0;
        for (int k = 0; k < 60 && !halted; k++) begin
            r   = int'($urandom_range(0, 39));
            r32 = $urandom;
            v.req_stall = int'($urandom_range(0, 3));
            v.resp_dly  = int'($urandom_range(0, 3));
            v.rdy_dly   = int'($urandom_range(0, 3));
            v.npc_dly   = int'($urandom_range(0, 3));
            v.data      = $urandom;
            v.err       = (r == 0);
            v.exp_addr  = exp_pc;
            if (r == 1)      v.npc = {r32[31:2], 2'($urandom_range(1, 3))};
            else if (r < 10) v.npc = {r32[31:2], 2'b00};
            else             v.npc = exp_pc + 32'd4;
            if (v.err) begin
                halted = 1'b1;
            end else begin
                exp_count = exp_count + 32'd1;
                if (v.npc % 4 != 0) halted = 1'b1;
                else                exp_pc = v.npc;
            end
            v.exp_fault = halted;
            v.exp_count = exp_count;
            do_instr(v);
        end
        if (halted) check_halted(4);
        chk("rand_count", fetch_count, exp_count);
        chk("rand_fault", fetch_fault, 32'(halted));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
